mem_rsp_model: RTL and testbench
================================

Name: mem_rsp_model

Overview:
- Synthesizable memory-side responder for the physical-address memory port.
- Accepts requests presented on mem_req_o_* by the design and returns responses on mem_res_i_*.
- Backing store is a small line-granular array; responses are returned in order after a fixed minimum latency.
- Used in benches and FPGA bring-up in place of a real memory controller.

Parameters:
- IDX_W, 4, width of transaction index (mem_t).
- MCN_W, 64, width of mcn field.
- PCN_W, 28, width of pcn (physical cache-line number).
- MEM_DEPTH, 64, lines in backing store (power of two).
- LAT, 4, minimum cycles from request acceptance to res_valid (≥1).
- QUE_DEPTH, 4, outstanding transactions (power of two, ≥2).

Ports:
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_valid  input  1  request valid.
- req_bits_idx  input  IDX_W  transaction index.
- req_bits_wnr  input  1  1=write, 0=read.
- req_bits_siz  input  3  log2 byte size.
- req_bits_mcn  input  MCN_W  ignored; present for port completeness.
- req_bits_pcn  input  PCN_W  line address.
- req_bits_data  input  512  write line data.
- res_ready  input  1  response consumed when res_valid && res_ready.
- res_valid  output  1  response valid.
- res_bits_idx  output  IDX_W  echoed idx.
- res_bits_err  output  1  error flag.
- res_bits_wnr  output  1  echoed wnr.
- res_bits_siz  output  3  echoed siz.
- res_bits_data  output  512  read data; 0 for writes and errors.

Behaviour:
- Reset values: req_ready=0 while reset asserted, 1 on the first cycle after deassertion; res_valid=0; res_bits_* all 0. Queue pointers, count and age counters are cleared.
- Reset does not clear the backing store.
- Reset mid-operation drops all queued transactions; no response is emitted for them.
- Error check at acceptance: err=1 if pcn ≥ MEM_DEPTH (any upper bit set) or wnr && siz≠6.
  - Erroring writes do not modify memory.
  - Erroring reads return data 0.
- Memory access is performed in the accept cycle:
  - Write stores the full 512-bit line at mem[pcn[log2(MEM_DEPTH)-1:0]].
  - Read captures the line into the queue entry.
  - A read accepted after a write to the same line returns the new data.
- Queue: circular FIFO of QUE_DEPTH entries {idx, err, wnr, siz, data, age}. Wrap-around by pointer modulo QUE_DEPTH; count is log2(QUE_DEPTH)+1 bits.
- req_ready = (count < QUE_DEPTH). It is a registered function of count only, with no combinational path from res_ready. When full with a simultaneous pop, ready re-asserts the next cycle.
- Age: each entry's age starts at 0 on accept and increments each cycle, saturating at LAT. The head is eligible when age == LAT.
- Latency: a request accepted in cycle T has res_valid at the earliest in cycle T+LAT.
- Responses are strictly in acceptance order. A younger entry never overtakes the head.
- Output handshake: res_valid/res_bits are driven from the head entry. Once asserted, they stay stable until res_ready. Pop occurs on res_valid && res_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Empty: res_valid=0 and res_bits hold their last value.

Optional Feature:
- MEM_RSP_BP_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - req_ready is additionally forced to 0 when lfsr[1:0]==2'b00.
  - The head's eligibility additionally requires lfsr[3:2]≠2'b00.
  - Ordering and data rules are unchanged.
- Undefined: no LFSR; behaviour exactly as above.

Test Plan:
- Write pcn=5, siz=6, data=512'hA5..A5, idx=3 → response at accept+4 with idx=3, wnr=1, err=0, data=0. Then read pcn=5, idx=4 → data=512'hA5..A5, err=0.
- Back-to-back 6 reads, res_ready=1 → req_ready drops after 4th accept, rises the cycle after first pop. Responses return idx order 0..5, each ≥4 cycles after its accept.
- res_ready=0 for 10 cycles with 1 pending read → res_valid high from accept+4, bits stable throughout. Pop occurs on res_ready rise.
- Read pcn=64 → err=1, data=0. Write pcn=2 siz=3 → err=1, and a later read pcn=2 returns the prior contents.
- Assert reset with 3 entries queued → res_valid=0 immediately, no stale responses after release. Read of a previously written line still returns its data.
- With MEM_RSP_BP_EN, 200 random read/write requests → scoreboard matches data, in-order idx, and zero lost/duplicated responses.

Source files
------------

// File: rtl/mem_rsp_model.sv
// Memory-side responder: line-granular backing store, in-order response FIFO, fixed minimum latency.
// Define MEM_RSP_BP_EN to add LFSR-driven pseudo-random backpressure on both handshakes.
module mem_rsp_model #(
  parameter int IDX_W     = 4,
  parameter int MCN_W     = 64,
  parameter int PCN_W     = 28,
  parameter int MEM_DEPTH = 64,
  parameter int LAT       = 4,
  parameter int QUE_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic             req_ready,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_bits_idx,
  input  logic             req_bits_wnr,
  input  logic [2:0]       req_bits_siz,
  input  logic [MCN_W-1:0] req_bits_mcn,
  input  logic [PCN_W-1:0] req_bits_pcn,
  input  logic [511:0]     req_bits_data,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_bits_idx,
  output logic             res_bits_err,
  output logic             res_bits_wnr,
  output logic [2:0]       res_bits_siz,
  output logic [511:0]     res_bits_data
);
  // Handshake: a beat transfers on the rising edge where valid && ready; once res_valid
  // rises, res_valid and res_bits hold steady until that transfer.
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int QW = $clog2(QUE_DEPTH);
  localparam int CW = QW + 1;
  localparam int GW = $clog2(LAT + 1);

  logic [511:0]     mem    [MEM_DEPTH];
  logic [IDX_W-1:0] q_idx  [QUE_DEPTH];
  logic             q_err  [QUE_DEPTH];
  logic             q_wnr  [QUE_DEPTH];
  logic [2:0]       q_siz  [QUE_DEPTH];
  logic [511:0]     q_data [QUE_DEPTH];
  logic [GW-1:0]    q_age  [QUE_DEPTH];

  logic [QW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             rdy_q, shown;
  logic [IDX_W-1:0] hold_idx;
  logic             hold_err, hold_wnr;
  logic [2:0]       hold_siz;
  logic [511:0]     hold_data;

  logic             push, pop, req_err, head_ok, bp_req, bp_head;
  logic [AW-1:0]    line;
  logic [511:0]     rd_line;
  logic             unused_mcn;

  assign unused_mcn = ^req_bits_mcn;

`ifdef MEM_RSP_BP_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign bp_req  = (lfsr[1:0] == 2'b00);
  assign bp_head = (lfsr[3:2] == 2'b00);
`else
  assign bp_req  = 1'b0;
  assign bp_head = 1'b0;
`endif

  assign req_ready = rdy_q & ~bp_req;
  assign push      = req_valid & req_ready;
  assign line      = req_bits_pcn[AW-1:0];
  assign req_err   = (|req_bits_pcn[PCN_W-1:AW]) | (req_bits_wnr & (req_bits_siz != 3'd6));
  assign rd_line   = (req_bits_wnr | req_err) ? '0 : mem[line];

  // Once presented, the head stays valid even if the backpressure source later blocks it.
  assign head_ok   = (count != '0) &&
                     (shown || ((q_age[rd_ptr] == GW'(LAT)) && !bp_head));
  assign res_valid = head_ok;
  assign pop       = res_valid & res_ready;

  assign res_bits_idx  = res_valid ? q_idx[rd_ptr]  : hold_idx;
  assign res_bits_err  = res_valid ? q_err[rd_ptr]  : hold_err;
  assign res_bits_wnr  = res_valid ? q_wnr[rd_ptr]  : hold_wnr;
  assign res_bits_siz  = res_valid ? q_siz[rd_ptr]  : hold_siz;
  assign res_bits_data = res_valid ? q_data[rd_ptr] : hold_data;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Backing store survives reset so lines written before a reset stay readable.
  always_ff @(posedge clock) begin
    if (push && req_bits_wnr && !req_err) mem[line] <= req_bits_data;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_idx[wr_ptr]  <= req_bits_idx;
      q_err[wr_ptr]  <= req_err;
      q_wnr[wr_ptr]  <= req_bits_wnr;
      q_siz[wr_ptr]  <= req_bits_siz;
      q_data[wr_ptr] <= rd_line;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rdy_q     <= 1'b0;
      shown     <= 1'b0;
      hold_idx  <= '0;
      hold_err  <= 1'b0;
      hold_wnr  <= 1'b0;
      hold_siz  <= '0;
      hold_data <= '0;
      for (int i = 0; i < QUE_DEPTH; i++) q_age[i] <= '0;
    end else begin
      for (int i = 0; i < QUE_DEPTH; i++) begin
        if (q_age[i] < GW'(LAT)) q_age[i] <= q_age[i] + GW'(1);
      end
      // Age 1 in the cycle after acceptance puts eligibility exactly LAT cycles after accept.
      if (push) begin
        q_age[wr_ptr] <= GW'(1);
        wr_ptr        <= wr_ptr + QW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + QW'(1);
        shown  <= 1'b0;
      end else if (res_valid) begin
        shown <= 1'b1;
      end
      if (res_valid) begin
        hold_idx  <= q_idx[rd_ptr];
        hold_err  <= q_err[rd_ptr];
        hold_wnr  <= q_wnr[rd_ptr];
        hold_siz  <= q_siz[rd_ptr];
        hold_data <= q_data[rd_ptr];
      end
      count <= count_nxt;
      rdy_q <= (count_nxt < CW'(QUE_DEPTH));
    end
  end
endmodule

// File: tb/tb_mem_rsp_model.sv
// Directed bench for mem_rsp_model: hand-computed vectors plus an in-order response scoreboard.
// Under MEM_RSP_BP_EN the exact-timing checks relax to minimum-latency checks.
module tb_mem_rsp_model;
  localparam int W = 521;

  logic         clock, reset;
  logic         req_ready, req_valid, req_bits_wnr;
  logic [3:0]   req_bits_idx;
  logic [2:0]   req_bits_siz;
  logic [63:0]  req_bits_mcn;
  logic [27:0]  req_bits_pcn;
  logic [511:0] req_bits_data;
  logic         res_ready, res_valid, res_bits_err, res_bits_wnr;
  logic [3:0]   res_bits_idx;
  logic [2:0]   res_bits_siz;
  logic [511:0] res_bits_data;

  mem_rsp_model dut (
    .clock(clock), .reset(reset),
    .req_ready(req_ready), .req_valid(req_valid), .req_bits_idx(req_bits_idx),
    .req_bits_wnr(req_bits_wnr), .req_bits_siz(req_bits_siz), .req_bits_mcn(req_bits_mcn),
    .req_bits_pcn(req_bits_pcn), .req_bits_data(req_bits_data),
    .res_ready(res_ready), .res_valid(res_valid), .res_bits_idx(res_bits_idx),
    .res_bits_err(res_bits_err), .res_bits_wnr(res_bits_wnr), .res_bits_siz(res_bits_siz),
    .res_bits_data(res_bits_data)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [511:0] model_mem [64];
  logic [W-1:0] last_rsp, prev_cur, cur, e;
  int           last_lat, n_pop, a;
  logic         prev_wait, e_err;
  logic [511:0] e_data;

  initial begin
    last_rsp = '0; prev_cur = '0; last_lat = 0; n_pop = 0; prev_wait = 1'b0;
  end

  always @(negedge clock) begin
    cur = {res_bits_idx, res_bits_err, res_bits_wnr, res_bits_siz, res_bits_data};
    if (!reset) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        check("stable_valid", res_valid, 1'b1);
        check("stable_bits", cur, prev_cur);
      end
      if (res_valid && res_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("spurious_rsp", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("rsp", cur, e);
          last_lat = cyc - a;
          check("rsp_lat_min", last_lat >= 4, 1'b1);
          last_rsp = cur;
        end
      end
      prev_wait = res_valid && !res_ready;
      prev_cur  = cur;
      if (req_valid && req_ready) begin
        e_err  = (req_bits_pcn >= 28'd64) || (req_bits_wnr && req_bits_siz != 3'd6);
        e_data = (req_bits_wnr || e_err) ? '0 : model_mem[req_bits_pcn[5:0]];
        if (req_bits_wnr && !e_err) model_mem[req_bits_pcn[5:0]] = req_bits_data;
        exp_q.push_back({req_bits_idx, e_err, req_bits_wnr, req_bits_siz, e_data});
        acc_q.push_back(cyc);
      end
    end
  end

  // driver tasks (called in the posedge+1 phase, return in the same phase)
  logic rand_en;

  task automatic send(input logic [3:0] idx, input logic wnr, input logic [2:0] siz,
                      input logic [27:0] pcn, input logic [511:0] data);
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1; req_bits_idx = idx; req_bits_wnr = wnr; req_bits_siz = siz;
    req_bits_pcn = pcn; req_bits_data = data; req_bits_mcn = {$urandom(), $urandom()};
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clock);
      ok = req_ready;
      @(posedge clock); #1;
      if (rand_en) res_ready = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    check("send_acc", ok, 1'b1);
  endtask

  task automatic drain(input int budget);
    for (int t = 0; t < budget; t++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !res_valid) break;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clock); #1;
  endtask

  logic [511:0] a5, pat;
  logic [59:0]  rdy_h, pop_h;
  int           k, first, stale, base;
  logic         wnr_r;
  int           r;

  initial begin
    a5 = {64{8'hA5}};
    reset = 1'b0; rand_en = 1'b0; res_ready = 1'b1;
    req_valid = 1'b0; req_bits_idx = '0; req_bits_wnr = 1'b0; req_bits_siz = '0;
    req_bits_mcn = '0; req_bits_pcn = '0; req_bits_data = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_idx", res_bits_idx, 4'd0);
    check("rst_res_data", res_bits_data, 512'd0);
    reset = 1'b1;
    check("rel_ready_low", req_ready, 1'b0);
    @(posedge clock); #1;
    check("rel_ready_high", req_ready, 1'b1);

    // write then read line 5
    send(4'd3, 1'b1, 3'd6, 28'd5, a5);
    drain(50);
`ifdef MEM_RSP_BP_EN
    check("wr_lat_min", last_lat >= 4, 1'b1);
`else
    check("wr_lat", last_lat, 4);
`endif
    check("wr_rsp", last_rsp, {4'd3, 1'b0, 1'b1, 3'd6, 512'd0});
    send(4'd4, 1'b0, 3'd6, 28'd5, '0);
    drain(50);
    check("rd5_rsp", last_rsp, {4'd4, 1'b0, 1'b0, 3'd6, a5});
    check("empty_valid", res_valid, 1'b0);
    check("empty_hold", {res_bits_idx, res_bits_data}, {4'd4, a5});

    // preload lines 0..7 except 5
    for (int i = 0; i < 8; i++) begin
      if (i != 5) begin
        pat = {16{32'h1000_0000 + i}};
        send(4'(i), 1'b1, 3'd6, 28'(i), pat);
      end
    end
    drain(100);

    // back-to-back reads idx 0..5
    k = 0; rdy_h = '0; pop_h = '0;
    req_valid = 1'b1; req_bits_wnr = 1'b0; req_bits_siz = 3'd6;
    req_bits_idx = 4'd0; req_bits_pcn = 28'd0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clock);
      rdy_h[j] = req_ready;
      pop_h[j] = res_valid && res_ready;
      if (req_valid && req_ready) k++;
      @(posedge clock); #1;
      if (k >= 6) req_valid = 1'b0;
      else begin
        req_bits_idx = 4'(k);
        req_bits_pcn = 28'(k);
      end
    end
    check("bb_accepts", k, 6);
`ifndef MEM_RSP_BP_EN
    check("bb_rdy_4th", rdy_h[3], 1'b1);
    check("bb_rdy_drop", rdy_h[4], 1'b0);
    check("bb_first_pop", pop_h[4], 1'b1);
    check("bb_rdy_rise", rdy_h[5], 1'b1);
`endif
    drain(100);
    check("bb_last", last_rsp, {4'd5, 1'b0, 1'b0, 3'd6, a5});

    // stalled response held for 10+ cycles
    res_ready = 1'b0;
    send(4'd7, 1'b0, 3'd6, 28'd1, '0);
    first = -1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clock);
      if (res_valid && first < 0) first = j;
    end
`ifndef MEM_RSP_BP_EN
    check("stall_first_valid", first, 4);
`endif
    check("stall_still_valid", res_valid, 1'b1);
    check("stall_bits", {res_bits_idx, res_bits_data}, {4'd7, {16{32'h1000_0001}}});
    @(posedge clock); #1;
    res_ready = 1'b1;
    drain(50);

    // error cases
    send(4'd8, 1'b0, 3'd6, 28'd64, '0);
    drain(50);
    check("err_pcn", last_rsp, {4'd8, 1'b1, 1'b0, 3'd6, 512'd0});
    send(4'd9, 1'b1, 3'd3, 28'd2, '1);
    drain(50);
    check("err_siz", last_rsp, {4'd9, 1'b1, 1'b1, 3'd3, 512'd0});
    send(4'd10, 1'b0, 3'd6, 28'd2, '0);
    drain(50);
    check("err_nowrite", last_rsp, {4'd10, 1'b0, 1'b0, 3'd6, {16{32'h1000_0002}}});

    // reset with three entries queued
    res_ready = 1'b0;
    send(4'd11, 1'b0, 3'd6, 28'd5, '0);
    send(4'd12, 1'b0, 3'd6, 28'd1, '0);
    send(4'd13, 1'b0, 3'd6, 28'd2, '0);
    repeat (4) @(posedge clock);
    #1;
    check("pre_rst_valid", res_valid, 1'b1);
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midrst_valid", res_valid, 1'b0);
    check("midrst_ready", req_ready, 1'b0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    res_ready = 1'b1;
    stale = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      if (res_valid) stale++;
    end
    check("no_stale", stale, 0);
    @(posedge clock); #1;
    send(4'd14, 1'b0, 3'd6, 28'd5, '0);
    drain(50);
    check("mem_kept", last_rsp, {4'd14, 1'b0, 1'b0, 3'd6, a5});

    // 200 random requests with random res_ready
    base = n_pop;
    rand_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wnr_r = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      send(4'(i), wnr_r,
           (wnr_r && $urandom_range(0, 4) != 0) ? 3'd6 : 3'($urandom_range(0, 7)),
           (r < 8) ? 28'(r) : 28'(64 + r * 7),
           {16{$urandom()}});
    end
    rand_en = 1'b0;
    res_ready = 1'b1;
    drain(500);
    check("rand_rsp_count", n_pop - base, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
